// File: rtl/bias_fetcher_pkg.sv
// Shared constants, layer indices, FSM encoding and SRAM address helper for the
// bias fetch path.
package bias_pkg;

    localparam int BW_PER_PARAM = 10;
    localparam int NUM_LAYERS   = 8;
    localparam int CH_PER_LAYER = 3;
    localparam int SRAM_DEPTH   = NUM_LAYERS * CH_PER_LAYER;
    localparam int LAYER_W      = $clog2(NUM_LAYERS);
    localparam int ADDR_W       = $clog2(SRAM_DEPTH);

    localparam logic [LAYER_W-1:0] L_CONV1   = 3'd0;
    localparam logic [LAYER_W-1:0] L_CONV2   = 3'd1;
    localparam logic [LAYER_W-1:0] L_CONV3_1 = 3'd2;
    localparam logic [LAYER_W-1:0] L_CONV3   = 3'd3;
    localparam logic [LAYER_W-1:0] L_CONV4_1 = 3'd4;
    localparam logic [LAYER_W-1:0] L_CONV4_2 = 3'd5;
    localparam logic [LAYER_W-1:0] L_CONV4   = 3'd6;
    localparam logic [LAYER_W-1:0] L_CONV5   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // layer*3 as shift-and-add; the largest result (21) fits the 5-bit address
    function automatic logic [ADDR_W-1:0] bias_addr(input logic [LAYER_W-1:0] layer);
        logic [ADDR_W-1:0] l;
        l = ADDR_W'(layer);
        return (l << 1) + l;
    endfunction

endpackage

// File: rtl/bias_fetcher_if.sv
// Sequencer request, bias SRAM read port and conv-engine bias handshake bundled
// together; slave is the fetcher, master is its environment.
interface bias_fetcher_if import bias_pkg::*; ();

    logic                    req_valid;
    logic                    req_ready;
    logic [LAYER_W-1:0]      req_layer;
    logic                    invalidate;

    logic                    sram_csb;
    logic                    sram_wsb;
    logic [ADDR_W-1:0]       sram_raddr;
    logic [BW_PER_PARAM-1:0] sram_rdata;

    logic                    bias_valid;
    logic                    bias_ready;
    logic [BW_PER_PARAM-1:0] bias0;
    logic [BW_PER_PARAM-1:0] bias1;
    logic [BW_PER_PARAM-1:0] bias2;

    modport slave (
        input  req_valid, req_layer, invalidate, sram_rdata, bias_ready,
        output req_ready, sram_csb, sram_wsb, sram_raddr,
               bias_valid, bias0, bias1, bias2
    );

    modport master (
        output req_valid, req_layer, invalidate, sram_rdata, bias_ready,
        input  req_ready, sram_csb, sram_wsb, sram_raddr,
               bias_valid, bias0, bias1, bias2
    );

endinterface

// File: rtl/bias_fetcher.sv
// Per-layer bias fetch: three SRAM reads gathered into one valid/ready beat,
// with a single-entry layer tag cache that skips the SRAM on a repeat request.
module bias_fetcher import bias_pkg::*; (
    input  logic            clk,
    input  logic            rst_n,
    bias_fetcher_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_READ  = ST_READ;
    localparam logic [1:0] S_DRAIN = ST_DRAIN;
    localparam logic [1:0] S_OUT   = ST_OUT;

    logic [1:0]              state_reg;
    logic [1:0]              issue_cnt_reg;
    logic [ADDR_W-1:0]       base_reg;
    logic [ADDR_W-1:0]       raddr_reg;
    logic                    csb_reg;
    logic                    bias_valid_reg;
    logic [LAYER_W-1:0]      layer_reg;
    logic                    inv_seen_reg;
    logic                    cache_vld_reg;
    logic [LAYER_W-1:0]      cache_layer_reg;

    logic                    hit;
    logic [CH_PER_LAYER-1:0] cap_en;

    // An invalidate in the accept cycle must force a miss even on a tag match
    assign hit = cache_vld_reg && (bus.req_layer == cache_layer_reg) && !bus.invalidate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            issue_cnt_reg  <= 2'd0;
            base_reg       <= '0;
            raddr_reg      <= '0;
            csb_reg        <= 1'b1;
            bias_valid_reg <= 1'b0;
            layer_reg      <= '0;
            inv_seen_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        if (hit) begin
                            state_reg      <= S_OUT;
                            bias_valid_reg <= 1'b1;
                        end else begin
                            // First address goes out on the accept edge so the
                            // three reads occupy exactly three csb-low cycles.
                            state_reg     <= S_READ;
                            layer_reg     <= bus.req_layer;
                            base_reg      <= bias_addr(bus.req_layer);
                            raddr_reg     <= bias_addr(bus.req_layer);
                            csb_reg       <= 1'b0;
                            issue_cnt_reg <= 2'd1;
                            inv_seen_reg  <= bus.invalidate;
                        end
                    end
                end
                S_READ: begin
                    if (bus.invalidate) begin
                        inv_seen_reg <= 1'b1;
                    end
                    if (issue_cnt_reg == 2'(CH_PER_LAYER)) begin
                        csb_reg   <= 1'b1;
                        state_reg <= S_DRAIN;
                    end else begin
                        raddr_reg     <= base_reg + ADDR_W'(issue_cnt_reg);
                        issue_cnt_reg <= issue_cnt_reg + 2'd1;
                    end
                end
                S_DRAIN: begin
                    state_reg      <= S_OUT;
                    bias_valid_reg <= 1'b1;
                end
                S_OUT: begin
                    if (bus.bias_ready) begin
                        state_reg      <= S_IDLE;
                        bias_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Tag is only trusted if no invalidate arrived anywhere between accept and drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_reg   <= 1'b0;
            cache_layer_reg <= '0;
        end else if (bus.invalidate) begin
            cache_vld_reg <= 1'b0;
            if (state_reg == S_DRAIN) begin
                cache_layer_reg <= layer_reg;
            end
        end else if (state_reg == S_DRAIN) begin
            cache_layer_reg <= layer_reg;
            cache_vld_reg   <= !inv_seen_reg;
        end
    end

    // Read data lags its address by one cycle: word k lands when issue_cnt is k+2,
    // and the last word lands in DRAIN.
    for (genvar gi = 0; gi < CH_PER_LAYER; gi++) begin : g_bias
        logic [BW_PER_PARAM-1:0] word_reg;

        if (gi == CH_PER_LAYER - 1) begin : g_last
            assign cap_en[gi] = (state_reg == S_DRAIN);
        end else begin : g_mid
            assign cap_en[gi] = (state_reg == S_READ) && (issue_cnt_reg == 2'(gi + 2));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                word_reg <= '0;
            end else if (cap_en[gi]) begin
                word_reg <= bus.sram_rdata;
            end
        end
    end

    assign bus.req_ready  = (state_reg == S_IDLE);
    assign bus.sram_csb   = csb_reg;
    assign bus.sram_wsb   = 1'b1;
    assign bus.sram_raddr = raddr_reg;
    assign bus.bias_valid = bias_valid_reg;
    assign bus.bias0      = g_bias[0].word_reg;
    assign bus.bias1      = g_bias[1].word_reg;
    assign bus.bias2      = g_bias[2].word_reg;

endmodule

// File: doc/bias_fetcher.md
# bias_fetcher

Bias fetch controller sitting between the layer sequencer and the 24-entry × 10-bit bias SRAM, in front of the conv datapath. On a per-layer request it reads that layer's three consecutive bias words from the SRAM read port and presents them together to the conv engine through a valid/ready handshake. A single-entry layer tag cache skips the SRAM access when the same layer is requested again and no invalidate has occurred.

## Interface
Parameters:
- BW_PER_PARAM, 10, bits per bias word (signed two's complement, passed through unmodified)
- NUM_LAYERS, 8, layer slots in bias SRAM (conv1, conv2, conv3_1, conv3, conv4_1, conv4_2, conv4, conv5 = 0..7)
- CH_PER_LAYER, 3, bias words per layer; SRAM address = layer*3 + ch

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  layer fetch request
- req_ready  out  1  high only in IDLE
- req_layer  in  3  layer index 0..7
- invalidate  in  1  SRAM contents changed; clears cache tag
- sram_csb  out  1  SRAM chip enable, active low, registered
- sram_wsb  out  1  SRAM write enable, tied 1 (read-only client)
- sram_raddr  out  5  SRAM read address, registered
- sram_rdata  in  BW_PER_PARAM  SRAM read data, valid the cycle after the address cycle
- bias_valid  out  1  bias0..2 valid
- bias_ready  in  1  conv engine accepts
- bias0, bias1, bias2  out  BW_PER_PARAM each  biases for channel 0/1/2 of the layer

## Operation
- States: IDLE, READ, DRAIN, OUT.
- IDLE: req_ready=1. On req_valid:
  - Hit (cache_vld && req_layer==cache_layer && !invalidate) -> OUT; bias registers unchanged.
  - Otherwise miss -> READ; issue_cnt=0, base=(req_layer<<1)+req_layer (5-bit, max 21).
- READ: drives sram_csb=0, sram_raddr=base+issue_cnt for issue_cnt=0,1,2, then -> DRAIN. Each cycle it also captures sram_rdata from the previous address cycle into bias[issue_cnt-1].
- DRAIN: sram_csb=1; captures bias2; sets cache_layer=req layer; sets cache_vld=1 unless invalidate was seen since accept; -> OUT.
- OUT: bias_valid=1, bias0..2 stable. On bias_ready -> IDLE. bias_valid is held indefinitely without ready.
- invalidate:
  - Clears cache_vld in any state.
  - During READ/DRAIN: the fetch completes and is delivered, but cache_vld stays 0.
  - Asserted in the same cycle as accept: request is treated as a miss.
- No back-to-back overlap: a new request is accepted only in the cycle after the OUT handshake (IDLE).

## Timing
- Reset (async assert): state=IDLE, sram_csb=1, sram_wsb=1, sram_raddr=0, bias0..2=0, bias_valid=0, cache_vld=0, cache_layer=0. req_ready=1 combinationally from IDLE.
- Miss, accept at edge E0:
  - Cycles E0–E1, E1–E2, E2–E3: csb=0 with addresses base, base+1, base+2.
  - bias0 captured at E2, bias1 at E3, bias2 at E4.
  - bias_valid high from E4: 4 edges accept-to-valid.
- Hit, accept at E0: bias_valid high from E0 (1 edge); sram_csb stays 1.
- Handshake at edge Eh with bias_valid && bias_ready: bias_valid low and req_ready high after Eh.
- Reset mid-fetch: immediate return to reset values; a partial load is discarded and the cache is invalid.

## Structure
- Shared package bias_pkg:
  - NUM_LAYERS, CH_PER_LAYER, BW_PER_PARAM
  - layer index localparams (L_CONV1=0 … L_CONV5=7)
  - state enum type
  - bias_addr(layer) function returning layer*3
- Single module; no sub-module is warranted. The address generator and capture counter are local.

## Test plan
- SRAM preloaded with mem[i]=i+100 for i=0..23; request layer 2 -> csb low for 3 cycles at raddr 6,7,8; bias0/1/2=106/107/108; bias_valid rises exactly 4 edges after accept.
- Repeat layer 2 immediately -> hit: no csb activity, bias_valid 1 edge after accept, same values.
- Request layer 7 with bias_ready held low for 10 cycles -> raddr 21,22,23; outputs 121/122/123 stable; req_ready low until the handshake.
- Load layer 2, pulse invalidate, rewrite mem[6]=-5 (10'h3FB), request layer 2 -> miss re-read, bias0=10'h3FB.
- Invalidate asserted in the DRAIN cycle of a layer 4 fetch -> data 112/113/114 delivered; next layer 4 request is a miss.
- Deassert rst_n during READ (after the second address) -> csb=1, bias_valid=0, bias0..2=0 immediately; after release, layer 1 fetch returns 103/104/105.
